// File: rtl/pipe_ctrl.sv
// Pipeline hazard/forwarding control with a debug halt FSM and saturating performance counters.
// Forwarding and stall/flush decisions are combinational; state and counters update on clk.
module pipe_ctrl #(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rs1,
    input  logic [REG_AW-1:0] i_ex_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_regwrite,
    input  logic              i_ex_redirect,
    input  logic              i_mem_req,
    input  logic              i_mem_ready,
    input  logic              i_dbg_halt_req,
    input  logic              i_dbg_resume,
    input  logic              i_perf_clear,
    output logic              o_f_stall,
    output logic              o_d_bubble,
    output logic              o_e_flush,
    output logic              o_pipe_freeze,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_dbg_halted,
    output logic [CNT_W-1:0]  o_perf_cycles,
    output logic [CNT_W-1:0]  o_perf_stalls,
    output logic [CNT_W-1:0]  o_perf_flushes
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_drain_cnt, w_drain_nxt;
    logic             r_halted;
    logic [CNT_W-1:0] r_cycles, r_stalls, r_flushes;

    logic w_load_use, w_freeze, w_f_stall, w_d_bubble, w_e_flush;
    logic w_run;

    // Register x0 never carries a result, so it is never a forwarding source.
    always_comb begin
        o_fwd_a = 2'b00;
        if (i_mem_regwrite && i_mem_rd == i_ex_rs1 && i_mem_rd != '0)
            o_fwd_a = 2'b01;
        else if (i_wb_regwrite && i_wb_rd == i_ex_rs1 && i_wb_rd != '0)
            o_fwd_a = 2'b10;
    end

    always_comb begin
        o_fwd_b = 2'b00;
        if (i_mem_regwrite && i_mem_rd == i_ex_rs2 && i_mem_rd != '0)
            o_fwd_b = 2'b01;
        else if (i_wb_regwrite && i_wb_rd == i_ex_rs2 && i_wb_rd != '0)
            o_fwd_b = 2'b10;
    end

    assign w_load_use = i_ex_memread && (i_ex_rd != '0) &&
                        ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) ||
                         (i_id_use_rs2 && i_id_rs2 == i_ex_rd));

    assign w_freeze = (i_mem_req && !i_mem_ready) || (r_state == HALTED);
    assign w_run    = (r_state != HALTED);

    // Freeze masks everything; a redirect beats both hazard and drain stalls.
    always_comb begin
        w_f_stall   = 1'b0;
        w_d_bubble  = 1'b0;
        w_e_flush   = 1'b0;
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        if (!w_freeze) begin
            if (i_ex_redirect) begin
                w_e_flush = 1'b1;
            end else if (w_load_use || r_state == DRAIN) begin
                w_f_stall  = 1'b1;
                w_d_bubble = 1'b1;
            end
        end
        case (r_state)
            RUN: begin
                if (i_dbg_halt_req && !w_freeze) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = 4'(DRAIN_CYC);
                end
            end
            DRAIN: begin
                if (!w_freeze) begin
                    if (r_drain_cnt == 4'd1) begin
                        w_state_nxt = HALTED;
                        w_drain_nxt = 4'd0;
                    end else begin
                        w_drain_nxt = r_drain_cnt - 4'd1;
                    end
                end
            end
            HALTED: begin
                if (i_dbg_resume)
                    w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
                w_drain_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= RUN;
            r_drain_cnt <= 4'd0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_halted    <= (w_state_nxt == HALTED);
        end
    end

    // Counters saturate at all-ones; clear takes precedence over increment.
    always_ff @(posedge clk) begin
        if (!rstn || i_perf_clear) begin
            r_cycles  <= '0;
            r_stalls  <= '0;
            r_flushes <= '0;
        end else begin
            if (w_run && r_cycles != '1)
                r_cycles <= r_cycles + 1'b1;
            if (w_run && (w_f_stall || w_freeze) && r_stalls != '1)
                r_stalls <= r_stalls + 1'b1;
            if (w_e_flush && r_flushes != '1)
                r_flushes <= r_flushes + 1'b1;
        end
    end

    assign o_f_stall      = w_f_stall;
    assign o_d_bubble     = w_d_bubble;
    assign o_e_flush      = w_e_flush;
    assign o_pipe_freeze  = w_freeze;
    assign o_dbg_halted   = r_halted;
    assign o_perf_cycles  = r_cycles;
    assign o_perf_stalls  = r_stalls;
    assign o_perf_flushes = r_flushes;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs, a negedge monitor
// pops and compares. Counters are tracked by a small saturating model driven by the expected flags.
module tb_pipe_ctrl;
    localparam int AW   = 5;
    localparam int CW   = 8;
    localparam int DC   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [AW-1:0] i_id_rs1, i_id_rs2, i_ex_rs1, i_ex_rs2, i_ex_rd, i_mem_rd, i_wb_rd;
    logic          i_id_use_rs1, i_id_use_rs2, i_ex_regwrite, i_ex_memread;
    logic          i_mem_regwrite, i_wb_regwrite, i_ex_redirect, i_mem_req, i_mem_ready;
    logic          i_dbg_halt_req, i_dbg_resume, i_perf_clear;
    logic          o_f_stall, o_d_bubble, o_e_flush, o_pipe_freeze, o_dbg_halted;
    logic [1:0]    o_fwd_a, o_fwd_b;
    logic [CW-1:0] o_perf_cycles, o_perf_stalls, o_perf_flushes;

    pipe_ctrl #(.REG_AW(AW), .CNT_W(CW), .DRAIN_CYC(DC)) dut (
        .clk(clk), .rstn(rstn),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
        .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2), .i_ex_rd(i_ex_rd),
        .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread),
        .i_mem_rd(i_mem_rd), .i_mem_regwrite(i_mem_regwrite),
        .i_wb_rd(i_wb_rd), .i_wb_regwrite(i_wb_regwrite),
        .i_ex_redirect(i_ex_redirect), .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
        .i_dbg_halt_req(i_dbg_halt_req), .i_dbg_resume(i_dbg_resume), .i_perf_clear(i_perf_clear),
        .o_f_stall(o_f_stall), .o_d_bubble(o_d_bubble), .o_e_flush(o_e_flush),
        .o_pipe_freeze(o_pipe_freeze), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
        .o_dbg_halted(o_dbg_halted), .o_perf_cycles(o_perf_cycles),
        .o_perf_stalls(o_perf_stalls), .o_perf_flushes(o_perf_flushes)
    );

    typedef struct {
        string         nm;
        logic          rstn;
        logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
        logic          id_u1, id_u2, ex_rw, ex_mr, mem_rw, wb_rw;
        logic          redir, mreq, mrdy, halt, resume, clr;
        logic          fs, db, ef, fz, hl;
        logic [1:0]    fa, fb;
    } vec_t;

    typedef struct {
        string      nm;
        logic       fs, db, ef, fz, hl;
        logic [1:0] fa, fb;
        int         cyc, stl, fls;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cyc = 0;
    int   m_stl = 0;
    int   m_fls = 0;
    vec_t v;

    function automatic vec_t blank(input string nm);
        vec_t x;
        x.nm = nm; x.rstn = 1'b1;
        x.id_rs1 = '0; x.id_rs2 = '0; x.ex_rs1 = '0; x.ex_rs2 = '0;
        x.ex_rd = '0; x.mem_rd = '0; x.wb_rd = '0;
        x.id_u1 = 0; x.id_u2 = 0; x.ex_rw = 0; x.ex_mr = 0; x.mem_rw = 0; x.wb_rw = 0;
        x.redir = 0; x.mreq = 0; x.mrdy = 0; x.halt = 0; x.resume = 0; x.clr = 0;
        x.fs = 0; x.db = 0; x.ef = 0; x.fz = 0; x.hl = 0; x.fa = 2'b00; x.fb = 2'b00;
        return x;
    endfunction

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d want %0d", nm, f, act, exp);
        end
    endtask

    // Drive one cycle's inputs, queue the expected response, then advance the counter model.
    task automatic issue(input vec_t x);
        exp_t e;
        @(posedge clk); #1;
        rstn = x.rstn;
        i_id_rs1 = x.id_rs1; i_id_rs2 = x.id_rs2; i_id_use_rs1 = x.id_u1; i_id_use_rs2 = x.id_u2;
        i_ex_rs1 = x.ex_rs1; i_ex_rs2 = x.ex_rs2; i_ex_rd = x.ex_rd;
        i_ex_regwrite = x.ex_rw; i_ex_memread = x.ex_mr;
        i_mem_rd = x.mem_rd; i_mem_regwrite = x.mem_rw; i_wb_rd = x.wb_rd; i_wb_regwrite = x.wb_rw;
        i_ex_redirect = x.redir; i_mem_req = x.mreq; i_mem_ready = x.mrdy;
        i_dbg_halt_req = x.halt; i_dbg_resume = x.resume; i_perf_clear = x.clr;
        e.nm = x.nm; e.fs = x.fs; e.db = x.db; e.ef = x.ef; e.fz = x.fz; e.hl = x.hl;
        e.fa = x.fa; e.fb = x.fb; e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls;
        q.push_back(e);
        if (!x.rstn || x.clr) begin
            m_cyc = 0; m_stl = 0; m_fls = 0;
        end else begin
            if (!x.hl && m_cyc < CMAX) m_cyc++;
            if (!x.hl && (x.fs || x.fz) && m_stl < CMAX) m_stl++;
            if (x.ef && m_fls < CMAX) m_fls++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.nm, "f_stall",  32'(o_f_stall),     32'(e.fs));
            chk(e.nm, "d_bubble", 32'(o_d_bubble),    32'(e.db));
            chk(e.nm, "e_flush",  32'(o_e_flush),     32'(e.ef));
            chk(e.nm, "freeze",   32'(o_pipe_freeze), 32'(e.fz));
            chk(e.nm, "fwd_a",    32'(o_fwd_a),       32'(e.fa));
            chk(e.nm, "fwd_b",    32'(o_fwd_b),       32'(e.fb));
            chk(e.nm, "halted",   32'(o_dbg_halted),  32'(e.hl));
            chk(e.nm, "cycles",   32'(o_perf_cycles), e.cyc);
            chk(e.nm, "stalls",   32'(o_perf_stalls), e.stl);
            chk(e.nm, "flushes",  32'(o_perf_flushes), e.fls);
        end
    end

    initial begin
        v = blank("init"); v.rstn = 1'b0;
        rstn = 0; i_id_rs1 = '0; i_id_rs2 = '0; i_ex_rs1 = '0; i_ex_rs2 = '0; i_ex_rd = '0;
        i_mem_rd = '0; i_wb_rd = '0; i_id_use_rs1 = 0; i_id_use_rs2 = 0; i_ex_regwrite = 0;
        i_ex_memread = 0; i_mem_regwrite = 0; i_wb_regwrite = 0; i_ex_redirect = 0;
        i_mem_req = 0; i_mem_ready = 0; i_dbg_halt_req = 0; i_dbg_resume = 0; i_perf_clear = 0;
        repeat (2) @(posedge clk);

        v = blank("reset"); v.rstn = 1'b0; issue(v);
        v = blank("idle"); issue(v);

        // forwarding
        v = blank("fwd_mem_prio"); v.mem_rd = 3; v.wb_rd = 3; v.ex_rs1 = 3;
        v.mem_rw = 1; v.wb_rw = 1; v.fa = 2'b01; issue(v);
        v.nm = "fwd_rs1_zero"; v.mem_rd = 0; v.wb_rd = 0; v.ex_rs1 = 0; v.fa = 2'b00; issue(v);
        v = blank("fwd_wb"); v.wb_rd = 3; v.wb_rw = 1; v.mem_rd = 3; v.mem_rw = 0;
        v.ex_rs1 = 3; v.ex_rs2 = 3; v.fa = 2'b10; v.fb = 2'b10; issue(v);
        v = blank("fwd_mix"); v.mem_rd = 4; v.mem_rw = 1; v.ex_rs2 = 4; v.wb_rd = 7; v.wb_rw = 1;
        v.ex_rs1 = 7; v.fa = 2'b10; v.fb = 2'b01; issue(v);

        // load-use hazards
        v = blank("lu_rs2"); v.ex_mr = 1; v.ex_rd = 5; v.id_rs2 = 5; v.id_u2 = 1;
        v.fs = 1; v.db = 1; issue(v);
        v = blank("lu_gone"); issue(v);
        v = blank("lu_unused"); v.ex_mr = 1; v.ex_rd = 5; v.id_rs2 = 5; issue(v);
        v = blank("lu_x0"); v.ex_mr = 1; v.ex_rd = 0; v.id_rs1 = 0; v.id_u1 = 1; issue(v);
        v = blank("lu_rs1"); v.ex_mr = 1; v.ex_rd = 9; v.id_rs1 = 9; v.id_u1 = 1;
        v.fs = 1; v.db = 1; issue(v);
        v = blank("lu_noload"); v.ex_rd = 9; v.id_rs1 = 9; v.id_u1 = 1; issue(v);
        v = blank("lu_redir"); v.ex_mr = 1; v.ex_rd = 5; v.id_rs2 = 5; v.id_u2 = 1;
        v.redir = 1; v.ef = 1; issue(v);

        // memory freeze masks the hazard, then the hazard stalls
        v = blank("lu_frz"); v.ex_mr = 1; v.ex_rd = 5; v.id_rs2 = 5; v.id_u2 = 1;
        v.mreq = 1; v.fz = 1;
        repeat (3) issue(v);
        v.nm = "lu_after_frz"; v.mrdy = 1; v.fz = 0; v.fs = 1; v.db = 1; issue(v);
        v = blank("mem_ok"); v.mreq = 1; v.mrdy = 1; issue(v);
        v = blank("frz_redir"); v.mreq = 1; v.redir = 1; v.fz = 1; issue(v);
        v = blank("clr_vs_inc"); v.ex_mr = 1; v.ex_rd = 5; v.id_rs2 = 5; v.id_u2 = 1;
        v.clr = 1; v.fs = 1; v.db = 1; issue(v);
        v = blank("post_clear"); issue(v);

        // halt with freeze and redirect during drain
        v = blank("halt_req"); v.halt = 1; issue(v);
        v = blank("drain1"); v.resume = 1; v.fs = 1; v.db = 1; issue(v);
        v = blank("drain_frz"); v.mreq = 1; v.fz = 1; repeat (2) issue(v);
        v = blank("drain2"); v.fs = 1; v.db = 1; issue(v);
        v = blank("drain_redir"); v.redir = 1; v.ef = 1; issue(v);
        v = blank("drain3"); v.fs = 1; v.db = 1; issue(v);
        v = blank("halted"); v.fz = 1; v.hl = 1; issue(v);
        v = blank("halted_haz"); v.ex_mr = 1; v.ex_rd = 5; v.id_rs2 = 5; v.id_u2 = 1;
        v.redir = 1; v.halt = 1; v.fz = 1; v.hl = 1; issue(v);
        v = blank("resume"); v.resume = 1; v.fz = 1; v.hl = 1; issue(v);
        v = blank("run_again"); issue(v);
        v = blank("resume_in_run"); v.resume = 1; issue(v);
        v = blank("run_chk"); issue(v);

        // reset from DRAIN
        v = blank("halt_req2"); v.halt = 1; issue(v);
        v = blank("drain_b"); v.fs = 1; v.db = 1; issue(v);
        v = blank("rst_drain"); v.rstn = 0; v.fs = 1; v.db = 1; issue(v);
        v = blank("after_rst_d"); issue(v);

        // reset from HALTED
        v = blank("halt_req3"); v.halt = 1; issue(v);
        v = blank("drain_c"); v.fs = 1; v.db = 1; repeat (DC) issue(v);
        v = blank("halted_c"); v.fz = 1; v.hl = 1; issue(v);
        v = blank("rst_halt"); v.rstn = 0; v.fz = 1; v.hl = 1; issue(v);
        v = blank("after_rst_h"); issue(v);

        // saturation and clear
        v = blank("sat_flush"); v.redir = 1; v.ef = 1; repeat (CMAX + 5) issue(v);
        v = blank("sat_stall"); v.mreq = 1; v.fz = 1; repeat (CMAX + 5) issue(v);
        v = blank("sat_hold"); v.redir = 1; v.ef = 1; issue(v);
        v = blank("sat_hold2"); v.ex_mr = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_u1 = 1;
        v.fs = 1; v.db = 1; issue(v);
        v = blank("sat_clear"); v.clr = 1; v.redir = 1; v.ef = 1; issue(v);
        v = blank("sat_zero"); issue(v);
        v = blank("sat_one"); issue(v);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
